// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch handshake, next-PC selection, fault vectoring
// and halt control. Every output is driven straight from a register.
module pc_sequencer #(
  parameter logic [0:31] EXC_VECTOR = 32'h0000_0080,
  parameter int          TIMEOUT    = 16,
  parameter logic [0:31] PC_STEP    = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:31] pc_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        instr_fetched,
  input  logic        resolve_valid,
  input  logic        redirect,
  input  logic [0:31] redirect_addr,
  input  logic        stall,
  input  logic        halt,
  output logic        pc_ctrl,
  output logic [0:31] new_addr,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        halted,
  output logic [31:0] retired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_UPDATE,
    S_FAULT,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              imem_req_q, imem_req_d;
  logic              fetched_q, fetched_d;
  logic              pc_ctrl_q, pc_ctrl_d;
  logic [0:31]       addr_q, addr_d;
  logic              fault_q, fault_d;
  logic [1:0]        cause_q, cause_d;
  logic              halted_q, halted_d;
  logic [31:0]       retired_q, retired_d;

  logic              take_fault;
  logic [1:0]        fault_kind;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      imem_req_q <= 1'b0;
      fetched_q  <= 1'b0;
      pc_ctrl_q  <= 1'b0;
      addr_q     <= '0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      imem_req_q <= imem_req_d;
      fetched_q  <= fetched_d;
      pc_ctrl_q  <= pc_ctrl_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    retired_d  = retired_q;
    fetched_d  = 1'b0;
    take_fault = 1'b0;
    fault_kind = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d   = S_EXEC;
          cnt_d     = '0;
          fetched_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          take_fault = 1'b1;
          fault_kind = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        // halt outranks both stall and a same-cycle resolve
        if (halt) begin
          state_d = S_HALT;
        end else if (!stall && resolve_valid) begin
          if (redirect && (redirect_addr[30:31] != 2'b00)) begin
            take_fault = 1'b1;
            fault_kind = CAUSE_MISALIGN;
          end else begin
            addr_d  = redirect ? redirect_addr : pc_addr + PC_STEP;
            state_d = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (take_fault) begin
      state_d = S_FAULT;
      addr_d  = EXC_VECTOR;
      fault_d = 1'b1;
      // only the first fault since reset records its cause
      if (!fault_q) begin
        cause_d = fault_kind;
      end
    end

    imem_req_d = (state_d == S_FETCH);
    pc_ctrl_d  = (state_d == S_UPDATE) || (state_d == S_FAULT);
    halted_d   = (state_d == S_HALT);
  end

  assign imem_req      = imem_req_q;
  assign instr_fetched = fetched_q;
  assign pc_ctrl       = pc_ctrl_q;
  assign new_addr      = addr_q;
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign halted        = halted_q;
  assign retired       = retired_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle fetch/update controller for the 32-bit program counter register.
- Drives the PC's load enable (pc_ctrl) and next address (new_addr).
- Handshakes with instruction memory, applies redirects (branch/jump) from the control unit, and vectors to an exception address on misaligned targets or fetch timeout.
- Counts retired instructions and supports a halt state.

Parameters:
- EXC_VECTOR, 32'h0000_0080, address loaded into PC on any fault.
- TIMEOUT, 16, max cycles FETCH waits for imem_ready before faulting (must be >= 1).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  clock; block logic on posedge (PC register samples on negedge).
- reset  input  1  synchronous, active-high.
- pc_addr  input  32  current PC value (bit 0 = MSB, bit 31 = LSB).
- imem_req  output  1  fetch request to instruction memory for pc_addr.
- imem_ready  input  1  instruction word valid this cycle.
- instr_fetched  output  1  one-cycle pulse: instruction captured, decode may start.
- resolve_valid  input  1  control unit has resolved next-PC for the current instruction.
- redirect  input  1  qualifies resolve_valid: take redirect_addr instead of pc_addr+PC_STEP.
- redirect_addr  input  32  branch/jump target.
- stall  input  1  hazard hold; resolve_valid ignored while high.
- halt  input  1  stop after current instruction, no PC update.
- pc_ctrl  output  1  load enable to PC register.
- new_addr  output  32  next PC value to PC register.
- fault  output  1  sticky fault flag.
- fault_cause  output  2  00 none, 01 misaligned target, 10 fetch timeout.
- halted  output  1  high in HALT state.
- retired  output  32  count of instructions whose PC update completed.

Behaviour:
- Reset (sync, active-high, priority over all): state=FETCH. pc_ctrl=0, new_addr=0, imem_req=0, instr_fetched=0, fault=0, fault_cause=00, halted=0, retired=0, timeout counter=0.
- States: FETCH, EXEC, UPDATE, FAULT, HALT. All outputs are registered.
- FETCH:
  - imem_req=1, and the timeout counter increments each cycle.
  - imem_ready=1 -> EXEC, instr_fetched pulses for one cycle, counter cleared.
  - Counter reaches TIMEOUT with no ready -> FAULT, cause=10.
- EXEC:
  - imem_req=0.
  - halt=1 -> HALT. halt wins over a same-cycle resolve_valid; no PC update, retired unchanged.
  - stall=1 -> hold in EXEC.
  - resolve_valid=1 & stall=0:
    - redirect=1 and redirect_addr[30:31]!=00 -> FAULT, cause=01.
    - Otherwise new_addr = redirect ? redirect_addr : pc_addr+PC_STEP (mod 2^32, wraps FFFF_FFFC->0000_0000), then -> UPDATE.
- UPDATE (exactly 1 cycle):
  - pc_ctrl=1, new_addr held, so the PC captures it on the mid-cycle negedge.
  - retired increments (wraps at 2^32), then -> FETCH with pc_ctrl=0.
- FAULT (exactly 1 cycle):
  - pc_ctrl=1, new_addr=EXC_VECTOR, fault=1 (sticky until reset).
  - fault_cause latches the first cause only; retired is not incremented. Then -> FETCH.
- HALT: halted=1, pc_ctrl=0, imem_req=0; exits only by reset.
- Latency: a non-stalled, non-faulting instruction with imem_ready on its first FETCH cycle takes 3 cycles (FETCH, EXEC, UPDATE).
- pc_ctrl is high only in UPDATE or FAULT. It is never high on two consecutive cycles.
- Reset mid-FETCH: imem_req deasserts at the reset edge. A late imem_ready in the cycle after reset counts as the fetch for PC=0.
- Inputs resolve_valid/redirect/stall/halt are ignored outside EXEC. imem_ready is ignored outside FETCH.

Test Plan:
- Sequential run: reset, imem_ready=1 each FETCH, resolve_valid with redirect=0 ×3 -> new_addr 4, 8, 12; pc_ctrl pulses every 3rd cycle; retired=3.
- Branch: at pc_addr=0x10, resolve_valid=1, redirect=1, redirect_addr=0x40 -> new_addr=0x40 in UPDATE, next imem_req with pc_addr=0x40; misaligned redirect_addr=0x42 -> FAULT, new_addr=0x80, fault=1, cause=01, retired unchanged.
- Timeout: imem_ready held 0 -> after 16 FETCH cycles FAULT, new_addr=0x80, cause=10. A later misaligned fault keeps cause=10.
- Stall/halt priority: stall=1 for 5 cycles with resolve_valid=1 -> no pc_ctrl until stall drops; then halt=1 with resolve_valid=1 same cycle -> HALT, halted=1, pc_ctrl never asserts.
- Wrap/reset: pc_addr=0xFFFF_FFFC, sequential -> new_addr=0. Reset asserted mid-FETCH -> next cycle all outputs at reset values, state FETCH.
